// File: rtl/demux_pkg.sv
// ============================================================================
// Module : demux_pkg
// Brief  : Shared defaults and types for the demux1x8_stream distribution block.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package demux_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_NUM_OUT = 8;
  localparam int DEF_SEL_W   = 4;
  localparam int DEF_CNT_W   = 8;

  typedef logic [DEF_DATA_W-1:0] lane_data_t;

  typedef enum logic [0:0] {
    LANE_EMPTY = 1'b0,
    LANE_FULL  = 1'b1
  } lane_state_t;

endpackage

`default_nettype wire

// File: rtl/demux_lane_reg.sv
// ============================================================================
// Module : demux_lane_reg
// Brief  : One-entry output holding register with valid/ready handshake.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module demux_lane_reg
  import demux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              ready_o
);

  lane_state_t       r_state;
  lane_state_t       w_next_state;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LANE_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      LANE_EMPTY: if (push)         w_next_state = LANE_FULL;
      LANE_FULL:  if (pop && !push) w_next_state = LANE_EMPTY;
      default:                      w_next_state = LANE_EMPTY;
    endcase
  end

  // Data is only loaded on push, so it keeps its last value after a pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else if (push) begin
      r_data <= data_i;
    end
  end

  assign data_o  = r_data;
  assign valid_o = (r_state == LANE_FULL);
  assign ready_o = !valid_o || pop;

endmodule

`default_nettype wire

// File: rtl/demux1x8_stream.sv
// ============================================================================
// Module : demux1x8_stream
// Brief  : Registered 1-to-N stream demultiplexer with per-lane holding
//          registers and a saturating counter of invalid-select drops.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module demux1x8_stream
  import demux_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int NUM_OUT = DEF_NUM_OUT,
  parameter int SEL_W   = DEF_SEL_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [NUM_OUT*DATA_W-1:0] out_data,
  output logic [NUM_OUT-1:0]        out_valid,
  input  logic [NUM_OUT-1:0]        out_ready,
  output logic [CNT_W-1:0]          drop_cnt,
  output logic                      busy
);

  localparam int c_lane_w = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  logic                w_sel_ok;
  logic                w_accept;
  logic [c_lane_w-1:0] w_lane_idx;
  logic [NUM_OUT-1:0]  w_push;
  logic [NUM_OUT-1:0]  w_pop;
  logic [NUM_OUT-1:0]  w_lane_ready;
  logic [CNT_W-1:0]    r_drop_cnt;

  // Extra top bit keeps the compare correct when NUM_OUT == 2**SEL_W.
  assign w_sel_ok   = ({1'b0, in_sel} < (SEL_W+1)'(NUM_OUT));
  assign w_lane_idx = in_sel[c_lane_w-1:0];
  assign in_ready   = w_sel_ok ? w_lane_ready[w_lane_idx] : 1'b1;
  assign w_accept   = in_valid && in_ready;

  generate
    for (genvar i = 0; i < NUM_OUT; i++) begin : g_lane
      assign w_push[i] = w_accept && w_sel_ok && (w_lane_idx == c_lane_w'(i));
      assign w_pop[i]  = out_valid[i] && out_ready[i];

      demux_lane_reg #(
        .DATA_W (DATA_W)
      ) u_lane (
        .clk     (clk),
        .rst     (rst),
        .push    (w_push[i]),
        .pop     (w_pop[i]),
        .data_i  (in_data),
        .data_o  (out_data[i*DATA_W +: DATA_W]),
        .valid_o (out_valid[i]),
        .ready_o (w_lane_ready[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (w_accept && !w_sel_ok && (r_drop_cnt != {CNT_W{1'b1}})) begin
      r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end
  end

  assign drop_cnt = r_drop_cnt;
  assign busy     = |out_valid;

endmodule

`default_nettype wire

// File: tb/tb_demux1x8_stream.sv
// ============================================================================
// Module : tb_demux1x8_stream
// Brief  : Directed and randomized self-checking bench for demux1x8_stream.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_demux1x8_stream;
  import demux_pkg::*;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic [3:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready;
  logic [7:0]  drop_cnt;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  demux1x8_stream dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .drop_cnt  (drop_cnt),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic lane_data_t lane(input int i);
    return out_data[i*8 +: 8];
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  lane_data_t sb_mem [8][4];
  int         sb_wr  [8];
  int         sb_rd  [8];
  int         exp_drop;
  logic [7:0] exp_vld;
  logic       exp_rdy;

  initial begin
    rst = 1'b1; in_data = '0; in_sel = '0; in_valid = 1'b0; out_ready = '0;
    step(); step();
    check("rst_valid", 64'(out_valid), 64'h0);
    check("rst_drop", 64'(drop_cnt), 64'h0);
    check("rst_ready", 64'(in_ready), 64'h1);
    check("rst_busy", 64'(busy), 64'h0);
    rst = 1'b0;
    step();

    // Fill lanes 0 and 3, drop one beat, then reset mid-cycle.
    in_valid = 1'b1; in_sel = 4'd0; in_data = 8'h11;
    step();
    check("t1_lane0", 64'(lane(0)), 64'h11);
    in_sel = 4'd3; in_data = 8'h33;
    step();
    in_sel = 4'd9; in_data = 8'h99;
    step();
    in_valid = 1'b0;
    check("t1_valid", 64'(out_valid), 64'h09);
    check("t1_drop", 64'(drop_cnt), 64'h1);
    check("t1_busy", 64'(busy), 64'h1);
    rst = 1'b1;
    #1;
    check("t1_async_valid", 64'(out_valid), 64'h0);
    check("t1_async_data", out_data, 64'h0);
    check("t1_async_drop", 64'(drop_cnt), 64'h0);
    step();
    rst = 1'b0;
    step();

    // Sweep all lanes with consumers always ready.
    out_ready = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_sel = 4'(i); in_data = 8'(8'hAA + i);
      #1;
      check("t2_ready", 64'(in_ready), 64'h1);
      step();
      check("t2_valid", 64'(out_valid), 64'(8'h01 << i));
      check("t2_data", 64'(lane(i)), 64'(8'hAA + i));
    end
    in_valid = 1'b0;
    step();
    check("t2_drained", 64'(out_valid), 64'h0);
    check("t2_hold_after_pop", 64'(lane(7)), 64'hB1);

    // Backpressure on lane 2.
    out_ready = 8'hFB;
    in_valid = 1'b1; in_sel = 4'd2; in_data = 8'hC1;
    #1;
    check("t3_ready1", 64'(in_ready), 64'h1);
    step();
    check("t3_c1", 64'(lane(2)), 64'hC1);
    in_data = 8'hC2;
    #1;
    check("t3_ready_stall", 64'(in_ready), 64'h0);
    step();
    check("t3_c1_held", 64'(lane(2)), 64'hC1);
    check("t3_valid_held", 64'(out_valid[2]), 64'h1);
    out_ready = 8'hFF;
    #1;
    check("t3_ready_pass", 64'(in_ready), 64'h1);
    step();
    check("t3_c2", 64'(lane(2)), 64'hC2);
    check("t3_valid_stay", 64'(out_valid[2]), 64'h1);
    in_valid = 1'b0; out_ready = 8'hFB;

    // Lane 5 proceeds while lane 2 is stalled.
    in_valid = 1'b1; in_sel = 4'd5; in_data = 8'h5A;
    #1;
    check("t4_ready", 64'(in_ready), 64'h1);
    step();
    in_valid = 1'b0;
    check("t4_lane5", 64'(lane(5)), 64'h5A);
    check("t4_valid", 64'(out_valid), 64'h24);
    check("t4_lane2", 64'(lane(2)), 64'hC2);
    step();
    check("t4_lane5_popped", 64'(out_valid), 64'h04);

    // Invalid selects are consumed and counted, then saturate.
    in_valid = 1'b1; in_sel = 4'd8; in_data = 8'hEE;
    #1;
    check("t5_ready8", 64'(in_ready), 64'h1);
    step();
    in_sel = 4'd15;
    #1;
    check("t5_ready15", 64'(in_ready), 64'h1);
    step();
    in_valid = 1'b0;
    check("t5_valid", 64'(out_valid), 64'h04);
    check("t5_drop2", 64'(drop_cnt), 64'h2);
    in_valid = 1'b1; in_sel = 4'd8;
    repeat (252) step();
    check("t5_drop254", 64'(drop_cnt), 64'd254);
    repeat (48) step();
    in_valid = 1'b0;
    check("t5_drop_sat", 64'(drop_cnt), 64'd255);
    check("t5_lanes_same", 64'(out_valid), 64'h04);
    check("t5_lane5_same", 64'(lane(5)), 64'h5A);

    rst = 1'b1; out_ready = 8'h00;
    step();
    rst = 1'b0;
    step();

    // Randomized traffic against a per-lane ordered scoreboard.
    exp_drop = 0;
    for (int l = 0; l < 8; l++) begin
      sb_wr[l] = 0; sb_rd[l] = 0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_sel    = 4'($urandom_range(0, 9));
      in_data   = 8'($urandom_range(8'hAA, 8'hEE));
      out_ready = 8'($urandom);
      #1;
      for (int l = 0; l < 8; l++) exp_vld[l] = (sb_wr[l] != sb_rd[l]);
      check("t6_valid", 64'(out_valid), 64'(exp_vld));
      exp_rdy = (in_sel >= 4'd8) ? 1'b1 : (!exp_vld[in_sel[2:0]] || out_ready[in_sel[2:0]]);
      check("t6_ready", 64'(in_ready), 64'(exp_rdy));
      for (int l = 0; l < 8; l++) begin
        if (exp_vld[l] && out_ready[l]) begin
          check("t6_data", 64'(lane(l)), 64'(sb_mem[l][sb_rd[l] % 4]));
          sb_rd[l]++;
        end
      end
      if (in_valid && exp_rdy) begin
        if (in_sel >= 4'd8) begin
          if (exp_drop < 255) exp_drop++;
        end else begin
          sb_mem[in_sel[2:0]][sb_wr[in_sel[2:0]] % 4] = in_data;
          sb_wr[in_sel[2:0]]++;
        end
      end
      step();
    end
    in_valid = 1'b0; out_ready = 8'hFF;
    for (int l = 0; l < 8; l++) begin
      if (sb_wr[l] != sb_rd[l]) begin
        check("t6_drain_data", 64'(lane(l)), 64'(sb_mem[l][sb_rd[l] % 4]));
        sb_rd[l]++;
      end
    end
    step();
    check("t6_drained", 64'(out_valid), 64'h0);
    check("t6_drop", 64'(drop_cnt), 64'(exp_drop));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
